// File: rtl/c66x_power_supervisor_if.sv
// Host/sequencer-facing signal bundle of the C66x power supervisor.
// master = host/bench side, slave = supervisor side.
interface c66x_power_supervisor_if;
    logic       power_req;
    logic       board_good;
    logic [3:0] seq_state;
    logic       enable;
    logic       fault;
    logic [2:0] retry_count;
    logic [2:0] sup_state;

    modport master (
        output power_req, board_good, seq_state,
        input  enable, fault, retry_count, sup_state
    );

    modport slave (
        input  power_req, board_good, seq_state,
        output enable, fault, retry_count, sup_state
    );
endinterface

// File: rtl/c66x_power_supervisor.sv
// DSP power supervisor: qualifies the host request, enables the power sequencer, retries or latches a fault.
// Optional macro C66X_SUPERVISOR_RETRY_EN enables retry/backoff; without it any failure latches FAULT.
module c66x_power_supervisor #(
    parameter int unsigned TICK_DIV         = 500,
    parameter int unsigned STARTUP_TICKS    = 100,
    parameter int unsigned ON_TIMEOUT_TICKS = 10000,
    parameter int unsigned BACKOFF_TICKS    = 500,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input logic                    sysclk,
    input logic                    reset,
    c66x_power_supervisor_if.slave bus
);
    localparam int unsigned TICK_W = 14;
    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = '1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_STARTUP  = 3'd1;
    localparam logic [2:0] ST_ENABLING = 3'd2;
    localparam logic [2:0] ST_RUNNING  = 3'd3;
    localparam logic [2:0] ST_BACKOFF  = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    localparam logic [3:0] SEQ_OFF = 4'b0000;
    localparam logic [3:0] SEQ_ON  = 4'b1001;

    if (MAX_RETRIES < 1 || MAX_RETRIES > 7) begin : g_bad_max_retries
        $error("MAX_RETRIES must be within 1..7");
    end

    logic [2:0]        state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d, pre_inc;
    logic [TICK_W-1:0] tick_q, tick_d, tick_inc;
    logic [2:0]        retry_q, retry_d;
    logic              enable_q, fault_q;
    logic              tick_wrap, abort, seq_on, seq_shutdown, fail;
`ifdef C66X_SUPERVISOR_RETRY_EN
    logic [2:0]        retry_sat;
`endif

    // "Reaching N" is judged on the value the tick counter takes at this edge.
    always_comb begin
        tick_wrap    = (pre_q == PRE_W'(TICK_DIV - 1));
        pre_inc      = tick_wrap ? '0 : pre_q + PRE_W'(1);
        tick_inc     = (tick_wrap && (tick_q != TICK_MAX)) ? tick_q + TICK_W'(1) : tick_q;
        abort        = !bus.power_req || !bus.board_good;
        seq_on       = (bus.seq_state == SEQ_ON);
        seq_shutdown = (bus.seq_state >= 4'b1010) && (bus.seq_state <= 4'b1110);
    end

`ifdef C66X_SUPERVISOR_RETRY_EN
    assign retry_sat = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;
`endif

    // Next-state decode; priority is abort > success > failure > timer.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.power_req && bus.board_good) state_d = ST_STARTUP;
            end
            ST_STARTUP: begin
                if (abort)                                          state_d = ST_IDLE;
                else if (tick_inc == TICK_W'(STARTUP_TICKS))        state_d = ST_ENABLING;
            end
            ST_ENABLING: begin
                if (abort) state_d = ST_IDLE;
                else if (seq_on) begin
                    state_d = ST_RUNNING;
                    retry_d = '0;
                end
                else if (seq_shutdown || (tick_inc == TICK_W'(ON_TIMEOUT_TICKS))) fail = 1'b1;
            end
            ST_RUNNING: begin
                if (abort)        state_d = ST_IDLE;
                else if (!seq_on) fail    = 1'b1;
            end
            ST_BACKOFF: begin
                if (abort) state_d = ST_IDLE;
                else if ((bus.seq_state == SEQ_OFF) && (tick_inc >= TICK_W'(BACKOFF_TICKS)))
                    state_d = ST_ENABLING;
            end
            ST_FAULT: begin
                if (!bus.power_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
`ifdef C66X_SUPERVISOR_RETRY_EN
            retry_d = retry_sat;
            state_d = (32'(retry_sat) >= MAX_RETRIES) ? ST_FAULT : ST_BACKOFF;
`else
            state_d = ST_FAULT;
`endif
        end

        if (state_d == ST_IDLE) retry_d = '0;
`ifndef C66X_SUPERVISOR_RETRY_EN
        retry_d = '0;
`endif
    end

    // Timebase restarts on every state change.
    always_comb begin
        if (state_d != state_q) begin
            pre_d  = '0;
            tick_d = '0;
        end else begin
            pre_d  = pre_inc;
            tick_d = tick_inc;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            tick_q   <= '0;
            retry_q  <= '0;
            enable_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            retry_q  <= retry_d;
            enable_q <= (state_d == ST_ENABLING) || (state_d == ST_RUNNING);
            fault_q  <= (state_d == ST_FAULT);
        end
    end

    assign bus.enable      = enable_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;
    assign bus.sup_state   = state_q;
endmodule

// File: tb/tb_c66x_power_supervisor.sv
// Scoreboard bench for c66x_power_supervisor: stimulus queues timed expectations, a monitor checks them.
module tb_c66x_power_supervisor;
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_ENAB = 3'd2,
                           S_RUN  = 3'd3, S_BACK  = 3'd4, S_FAULT = 3'd5;

    typedef struct packed {
        logic [31:0] cyc;
        logic [95:0] name;
        logic [2:0]  st;
        logic        en;
        logic        flt;
        logic [2:0]  rc;
    } exp_t;

    logic sysclk;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    c66x_power_supervisor_if bus();

    c66x_power_supervisor #(
        .TICK_DIV(2), .STARTUP_TICKS(5), .ON_TIMEOUT_TICKS(20),
        .BACKOFF_TICKS(4), .MAX_RETRIES(3)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    always @(posedge sysclk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
        $fatal(1);
    end

    task automatic expect_at(input int at, input logic [95:0] nm, input logic [2:0] st,
                             input logic en, input logic flt, input logic [2:0] rc);
        exp_t e;
        e.cyc = 32'(at); e.name = nm; e.st = st; e.en = en; e.flt = flt; e.rc = rc;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge sysclk);
    endtask

    // Monitor: outputs are sampled on the falling edge, cyc counts rising edges so far.
    initial begin
        exp_t e;
        forever begin
            @(negedge sysclk);
            while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (int'(e.cyc) != cyc || bus.sup_state !== e.st || bus.enable !== e.en ||
                    bus.fault !== e.flt || bus.retry_count !== e.rc) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got st=%0d en=%b flt=%b rc=%0d, want st=%0d en=%b flt=%b rc=%0d (due cyc %0d)",
                             e.name, cyc, bus.sup_state, bus.enable, bus.fault, bus.retry_count,
                             e.st, e.en, e.flt, e.rc, e.cyc);
                end
            end
        end
    end

    // From IDLE: request power, returns at the cycle ENABLING was entered.
    task automatic go_enabling(output int e);
        int b;
        b = cyc;
        bus.power_req = 1'b1; bus.board_good = 1'b1; bus.seq_state = 4'b0000;
        expect_at(b + 1,  "startup",     S_START, 1'b0, 1'b0, 3'd0);
        expect_at(b + 10, "startup_end", S_START, 1'b0, 1'b0, 3'd0);
        expect_at(b + 11, "enable_rise", S_ENAB,  1'b1, 1'b0, 3'd0);
        e = b + 11;
        wait_cyc(e);
    endtask

    // FAULT must ignore board_good and seq_state.
    task automatic fault_hold(input logic [2:0] rc);
        int b;
        b = cyc;
        bus.board_good = 1'b0; bus.seq_state = 4'b1001;
        expect_at(b + 2, "fault_hold", S_FAULT, 1'b0, 1'b1, rc);
        wait_cyc(b + 2);
    endtask

    task automatic leave_idle();
        int b;
        b = cyc;
        bus.power_req = 1'b0; bus.board_good = 1'b1; bus.seq_state = 4'b0000;
        expect_at(b + 1, "to_idle", S_IDLE, 1'b0, 1'b0, 3'd0);
        wait_cyc(b + 2);
    endtask

    initial begin
        int b, e;
        reset = 1'b1;
        bus.power_req = 1'b1; bus.board_good = 1'b1; bus.seq_state = 4'b0000;
        @(negedge sysclk);

        // Reset holds IDLE even with a qualified request.
        b = cyc;
        expect_at(b + 2, "reset_state", S_IDLE, 1'b0, 1'b0, 3'd0);
        wait_cyc(b + 2);
        reset = 1'b0;

        // Nominal power-up, sequencer reports on 12 cycles after enable.
        go_enabling(e);
        expect_at(e + 12, "wait_seq_on", S_ENAB, 1'b1, 1'b0, 3'd0);
        expect_at(e + 13, "running",     S_RUN,  1'b1, 1'b0, 3'd0);
        wait_cyc(e + 12);
        bus.seq_state = 4'b1001;
        wait_cyc(e + 15);

        // Sequencer drops into shutdown while running.
        b = cyc;
`ifdef C66X_SUPERVISOR_RETRY_EN
        expect_at(b + 1,  "run_fail",     S_BACK, 1'b0, 1'b0, 3'd1);
        expect_at(b + 8,  "backoff_hold", S_BACK, 1'b0, 1'b0, 3'd1);
        expect_at(b + 9,  "backoff_exit", S_ENAB, 1'b1, 1'b0, 3'd1);
        expect_at(b + 10, "retry_ok",     S_RUN,  1'b1, 1'b0, 3'd0);
        bus.seq_state = 4'b1010;
        wait_cyc(b + 1);
        bus.seq_state = 4'b0000;
        wait_cyc(b + 9);
        bus.seq_state = 4'b1001;
        wait_cyc(b + 11);
`else
        expect_at(b + 1, "run_fail", S_FAULT, 1'b0, 1'b1, 3'd0);
        bus.seq_state = 4'b1010;
        wait_cyc(b + 1);
        fault_hold(3'd0);
`endif
        leave_idle();

        // Enable timeouts with the sequencer stuck off.
        go_enabling(e);
        expect_at(e + 39, "enab_pre_to", S_ENAB, 1'b1, 1'b0, 3'd0);
`ifdef C66X_SUPERVISOR_RETRY_EN
        expect_at(e + 40,  "timeout1",   S_BACK,  1'b0, 1'b0, 3'd1);
        expect_at(e + 47,  "backoff1",   S_BACK,  1'b0, 1'b0, 3'd1);
        expect_at(e + 48,  "reenable1",  S_ENAB,  1'b1, 1'b0, 3'd1);
        expect_at(e + 88,  "timeout2",   S_BACK,  1'b0, 1'b0, 3'd2);
        expect_at(e + 96,  "reenable2",  S_ENAB,  1'b1, 1'b0, 3'd2);
        expect_at(e + 135, "enab3_hold", S_ENAB,  1'b1, 1'b0, 3'd2);
        expect_at(e + 136, "timeout3",   S_FAULT, 1'b0, 1'b1, 3'd3);
        wait_cyc(e + 136);
        fault_hold(3'd3);
`else
        expect_at(e + 40, "timeout1", S_FAULT, 1'b0, 1'b1, 3'd0);
        wait_cyc(e + 40);
        fault_hold(3'd0);
`endif
        leave_idle();

        // board_good glitch at tick 3 of STARTUP, then abort beats success.
        b = cyc;
        bus.power_req = 1'b1; bus.board_good = 1'b1; bus.seq_state = 4'b0000;
        expect_at(b + 1,  "glitch_start", S_START, 1'b0, 1'b0, 3'd0);
        expect_at(b + 7,  "glitch_tick3", S_START, 1'b0, 1'b0, 3'd0);
        expect_at(b + 8,  "glitch_idle",  S_IDLE,  1'b0, 1'b0, 3'd0);
        expect_at(b + 9,  "restart",      S_START, 1'b0, 1'b0, 3'd0);
        expect_at(b + 18, "restart_end",  S_START, 1'b0, 1'b0, 3'd0);
        expect_at(b + 19, "restart_enab", S_ENAB,  1'b1, 1'b0, 3'd0);
        expect_at(b + 20, "abort_wins",   S_IDLE,  1'b0, 1'b0, 3'd0);
        wait_cyc(b + 7);
        bus.board_good = 1'b0;
        wait_cyc(b + 8);
        bus.board_good = 1'b1;
        wait_cyc(b + 19);
        bus.power_req = 1'b0; bus.seq_state = 4'b1001;
        wait_cyc(b + 21);
        bus.seq_state = 4'b0000;

        // One-cycle reset while running.
        go_enabling(e);
        expect_at(e + 1, "rst_pre_run", S_RUN,   1'b1, 1'b0, 3'd0);
        expect_at(e + 3, "rst_mid_run", S_IDLE,  1'b0, 1'b0, 3'd0);
        expect_at(e + 4, "rst_restart", S_START, 1'b0, 1'b0, 3'd0);
        expect_at(e + 5, "rst_release", S_IDLE,  1'b0, 1'b0, 3'd0);
        bus.seq_state = 4'b1001;
        wait_cyc(e + 2);
        reset = 1'b1;
        wait_cyc(e + 3);
        reset = 1'b0;
        wait_cyc(e + 4);
        bus.power_req = 1'b0; bus.seq_state = 4'b0000;
        wait_cyc(e + 6);

        // Illegal state code must fall back to IDLE rather than act like it.
        b = cyc;
        bus.power_req = 1'b1; bus.board_good = 1'b1;
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        #1;
        checks++;
        if (bus.sup_state !== 3'd6) begin
            errors++;
            $display("FAIL forced_code: got st=%0d, want st=6", bus.sup_state);
        end
        expect_at(b + 1, "illegal_idle", S_IDLE,  1'b0, 1'b0, 3'd0);
        expect_at(b + 2, "illegal_next", S_START, 1'b0, 1'b0, 3'd0);
        expect_at(b + 3, "final_idle",   S_IDLE,  1'b0, 1'b0, 3'd0);
        wait_cyc(b + 2);
        bus.power_req = 1'b0;
        wait_cyc(b + 4);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge sysclk);
        if (exp_q.size() > 0) begin
            errors += exp_q.size();
            checks += exp_q.size();
            $display("FAIL drain: %0d expectations never checked", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/c66x_power_supervisor.md
C66X_POWER_SUPERVISOR -- requirements
Module: c66x_power_supervisor

Interface
REQ-001 Parameter TICK_DIV, default 500: sysclk cycles per 100us tick.
REQ-002 Parameter STARTUP_TICKS, default 100: ticks from qualified request to enable (10ms).
REQ-003 Parameter ON_TIMEOUT_TICKS, default 10000: ticks allowed for the sequencer to reach its on state (1s).
REQ-004 Parameter BACKOFF_TICKS, default 500: minimum ticks with enable low between attempts (50ms).
REQ-005 Parameter MAX_RETRIES, default 3, range 1-7: failed attempts tolerated before fault latch.
REQ-006 sysclk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 power_req  input  1  host request for DSP power; synchronous to sysclk.
REQ-009 board_good  input  1  board input supply good; synchronous to sysclk.
REQ-010 seq_state  input  4  downstream power-sequencer state (0000 off, 1001 on, 1010-1110 shutdown).
REQ-011 enable  output  1  enable to the downstream power sequencer.
REQ-012 fault  output  1  latched supervisor fault.
REQ-013 retry_count  output  3  failed attempts since last success or idle.
REQ-014 sup_state  output  3  current supervisor state encoding.

Function
REQ-015 States SHALL be IDLE=0, STARTUP=1, ENABLING=2, RUNNING=3, BACKOFF=4, FAULT=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-016 Outputs SHALL be Moore-decoded from the state register: enable=1 only in ENABLING and RUNNING; fault=1 only in FAULT.
REQ-017 Prescaler and 14-bit tick counter SHALL both clear on every state change; tick counter increments once per TICK_DIV cycles and saturates at 16383.
REQ-018 "Reaches N" SHALL mean tick counter == N; state exits after exactly N*TICK_DIV cycles in the state.
REQ-019 Priority in every non-IDLE, non-FAULT state: power_req low > board_good low > success > failure > timer expiry.
REQ-020 power_req low or board_good low SHALL go to IDLE from STARTUP, ENABLING, RUNNING, BACKOFF without counting a retry.
REQ-021 IDLE: retry_count SHALL clear; power_req & board_good -> STARTUP.
REQ-022 STARTUP: tick counter reaches STARTUP_TICKS -> ENABLING.
REQ-023 ENABLING: seq_state==1001 -> RUNNING and retry_count clears (success wins over simultaneous timeout).
REQ-024 ENABLING failure: seq_state in 1010-1110, or tick counter reaches ON_TIMEOUT_TICKS.
REQ-025 RUNNING failure: seq_state != 1001.
REQ-026 On failure retry_count SHALL increment; if the incremented value >= MAX_RETRIES -> FAULT, else -> BACKOFF.
REQ-027 BACKOFF: seq_state==0000 and tick counter >= BACKOFF_TICKS -> ENABLING (no STARTUP repeat).
REQ-028 FAULT: held regardless of board_good and seq_state; power_req low -> IDLE.
REQ-029 retry_count SHALL saturate at 7 and hold its value in FAULT.

Reset
REQ-030 While reset is high at an edge: state=IDLE, prescaler=0, tick counter=0, retry_count=0; hence enable=0, fault=0, sup_state=000 from the following cycle.
REQ-031 Reset mid-RUNNING SHALL drop enable the cycle after the reset edge; no retry is counted.

Configuration
REQ-032 Macro C66X_SUPERVISOR_RETRY_EN defined: retry/backoff behaviour per REQ-026/027.
REQ-033 Macro C66X_SUPERVISOR_RETRY_EN undefined: any failure -> FAULT directly, BACKOFF unreachable, retry_count tied to 000.

Verification (bench: TICK_DIV=2, STARTUP_TICKS=5, ON_TIMEOUT_TICKS=20, BACKOFF_TICKS=4, MAX_RETRIES=3)
REQ-034 reset released, power_req=board_good=1, seq_state driven 1001 12 cycles after enable rises -> enable rises exactly 10 cycles after STARTUP entry; sup_state 1->2->3; retry_count=0.
REQ-035 ENABLING with seq_state held 0000 -> failure at 40 cycles; retry_count=1; BACKOFF; enable low >=8 cycles; re-enters ENABLING once seq_state=0000.
REQ-036 Three consecutive ENABLING timeouts (RETRY_EN defined) -> FAULT, fault=1, retry_count=3; power_req low -> IDLE, fault=0, retry_count=0.
REQ-037 RUNNING, seq_state changes 1001->1010 -> BACKOFF, retry_count=1, enable low next cycle; same stimulus without RETRY_EN -> FAULT, retry_count=0.
REQ-038 STARTUP, board_good low for one cycle at tick 3 -> IDLE, no enable pulse; ENABLING with power_req falling and seq_state=1001 in same cycle -> IDLE.
REQ-039 reset asserted one cycle during RUNNING -> sup_state=000, enable=0 next cycle; force state code 6 -> IDLE next edge.
